dmem_arbiter: RTL and testbench

Sequencer and two-port arbiter in front of the 256-word data memory.
- After reset, or on request, it runs a clocked clear sweep that writes each word with its own address, one word per cycle.
- Otherwise it shares the memory's single WR/ADDRESS/BIN/DATAOUT port between port 0 (CPU load/store) and port 1 (debug/DMA loader) using round-robin arbitration.
- Sits between the core's MEM stage, the debug loader, and the DataMemory instance.

---
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Clear sequencer and round-robin two-port arbiter in front of the data memory.
// The sweep writes each word with its own address; otherwise ports 0/1 share the memory port.
module dmem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_start,
   output logic              busy,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_bin,
   input  logic [DATA_W-1:0] mem_dataout
);

   typedef enum logic {
      S_CLEAR,
      S_ARB
   } state_t;

   localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] cnt_nx;
   logic              last_gnt;
   logic              last_gnt_nx;

   // State, sweep counter and last-grant pointer; pointer starts at 1 so port 0 wins first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_CLEAR;
         cnt      <= '0;
         last_gnt <= 1'b1;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         last_gnt <= last_gnt_nx;
      end
   end

   // Next state, sweep drive and arbitration; reset overrides writes and grants.
   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      last_gnt_nx = last_gnt;
      busy        = 1'b0;
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_bin     = '0;
      unique case (state)
         S_CLEAR: begin
            busy     = 1'b1;
            mem_wr   = 1'b1;
            mem_addr = cnt;
            mem_bin  = DATA_W'(cnt);
            cnt_nx   = cnt + 1'b1;
            if (cnt == CNT_LAST) begin
               state_nx = S_ARB;
               cnt_nx   = '0;
            end
         end
         S_ARB: begin
            if (clear_start) begin
               state_nx = S_CLEAR;
               cnt_nx   = '0;
            end else begin
               gnt0 = req0 & (~req1 | last_gnt);
               gnt1 = req1 & (~req0 | ~last_gnt);
               unique case (1'b1)
                  gnt0: begin
                     mem_wr      = we0;
                     mem_addr    = addr0;
                     mem_bin     = wdata0;
                     last_gnt_nx = 1'b0;
                  end
                  gnt1: begin
                     mem_wr      = we1;
                     mem_addr    = addr1;
                     mem_bin     = wdata1;
                     last_gnt_nx = 1'b1;
                  end
                  default: begin
                     mem_wr = 1'b0;
                  end
               endcase
            end
         end
      endcase
      if (reset) begin
         busy   = 1'b1;
         mem_wr = 1'b0;
         gnt0   = 1'b0;
         gnt1   = 1'b0;
      end
   end

   // Port 0 read return: capture memory data on a read grant, valid for one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rvalid0 <= 1'b0;
         rdata0  <= '0;
      end else begin
         rvalid0 <= gnt0 & ~we0;
         if (gnt0 & ~we0) begin
            rdata0 <= mem_dataout;
         end
      end
   end

   // Port 1 read return: capture memory data on a read grant, valid for one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rvalid1 <= 1'b0;
         rdata1  <= '0;
      end else begin
         rvalid1 <= gnt1 & ~we1;
         if (gnt1 & ~we1) begin
            rdata1 <= mem_dataout;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, read-data scoreboards per port,
// and one task per scenario.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear_start;
   logic        busy;
   logic        req0, we0, gnt0, rvalid0;
   logic [7:0]  addr0;
   logic [31:0] wdata0, rdata0;
   logic        req1, we1, gnt1, rvalid1;
   logic [7:0]  addr1;
   logic [31:0] wdata1, rdata1;
   logic        mem_wr;
   logic [7:0]  mem_addr;
   logic [31:0] mem_bin;
   logic [31:0] mem_dataout;

   logic [31:0] bmem [256];
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];
   int          checks = 0;
   int          errors = 0;
   logic        exp_last;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk(clk), .reset(reset), .clear_start(clear_start), .busy(busy),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_bin(mem_bin),
      .mem_dataout(mem_dataout)
   );

   // Data memory stand-in: synchronous write, combinational read.
   always @(posedge clk) if (mem_wr) bmem[mem_addr] <= mem_bin;
   assign mem_dataout = bmem[mem_addr];

   // Read-return scoreboard: every rvalid must match a queued expectation.
   always @(negedge clk) begin
      if (rvalid0) begin
         checks++;
         if (q0.size() == 0) begin
            errors++;
            $display("FAIL rvalid0_unexpected: got rvalid0=1 rdata0=%h, want no read", rdata0);
         end else begin
            logic [31:0] e0;
            e0 = q0.pop_front();
            if (rdata0 !== e0) begin
               errors++;
               $display("FAIL rdata0: got %h want %h", rdata0, e0);
            end
         end
      end
      if (rvalid1) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL rvalid1_unexpected: got rvalid1=1 rdata1=%h, want no read", rdata1);
         end else begin
            logic [31:0] e1;
            e1 = q1.pop_front();
            if (rdata1 !== e1) begin
               errors++;
               $display("FAIL rdata1: got %h want %h", rdata1, e1);
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({busy, mem_wr, gnt0, gnt1, rvalid0, rvalid1} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 100000",
                  {busy, mem_wr, gnt0, gnt1, rvalid0, rvalid1});
      end
      checks++;
      if ({rdata0, rdata1} !== 64'h0) begin
         errors++;
         $display("FAIL reset_rdata: got %h %h want 0 0", rdata0, rdata1);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 256; k++) begin
         #1;
         checks++;
         if ({busy, mem_wr, mem_addr, mem_bin} !== {1'b1, 1'b1, 8'(k), 32'(k)}) begin
            errors++;
            $display("FAIL sweep k=%0d: got busy=%b wr=%b a=%h d=%h want 1 1 %h %h",
                     k, busy, mem_wr, mem_addr, mem_bin, 8'(k), 32'(k));
         end
         @(negedge clk);
      end
      #1;
      checks++;
      if ({busy, mem_wr, mem_addr, mem_bin} !== 42'h0) begin
         errors++;
         $display("FAIL sweep_end: got busy=%b wr=%b a=%h d=%h want idle zeros",
                  busy, mem_wr, mem_addr, mem_bin);
      end
      exp_last = 1'b1;
   endtask

   task automatic test_port0_rw();
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 32'hDEADBEEF;
      #1;
      checks++;
      if ({gnt0, gnt1, mem_wr, mem_addr, mem_bin} !== {3'b101, 8'h10, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL p0_write: got g0=%b g1=%b wr=%b a=%h d=%h want 1 0 1 10 deadbeef",
                  gnt0, gnt1, mem_wr, mem_addr, mem_bin);
      end
      exp_last = 1'b0;
      @(negedge clk);
      we0 = 1'b0;
      #1;
      checks++;
      if ({gnt0, mem_wr, mem_addr} !== {2'b10, 8'h10}) begin
         errors++;
         $display("FAIL p0_read_gnt: got g0=%b wr=%b a=%h want 1 0 10", gnt0, mem_wr, mem_addr);
      end
      q0.push_back(32'hDEADBEEF);
      @(negedge clk);
      req0 = 1'b0;
      #1;
      checks++;
      if ({gnt0, gnt1, mem_wr, mem_addr, mem_bin} !== 43'h0) begin
         errors++;
         $display("FAIL idle_bus: got g0=%b g1=%b wr=%b a=%h d=%h want zeros",
                  gnt0, gnt1, mem_wr, mem_addr, mem_bin);
      end
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (q0.size() != 0 || rdata0 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL p0_read_hold: got pending=%0d rdata0=%h want 0 deadbeef",
                  q0.size(), rdata0);
      end
   endtask

   task automatic test_round_robin();
      logic eg0;
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
      req1 = 1'b1; we1 = 1'b0; addr1 = 8'h06;
      for (int i = 0; i < 4; i++) begin
         #1;
         eg0 = exp_last;
         checks++;
         if ({gnt0, gnt1, mem_wr, mem_addr} !== {eg0, ~eg0, 1'b0, (eg0 ? 8'h05 : 8'h06)}) begin
            errors++;
            $display("FAIL rr_grant i=%0d: got g0=%b g1=%b wr=%b a=%h want g0=%b g1=%b",
                     i, gnt0, gnt1, mem_wr, mem_addr, eg0, ~eg0);
         end
         if (eg0) q0.push_back(32'h5);
         else     q1.push_back(32'h6);
         exp_last = ~eg0;
         @(negedge clk);
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL rr_drain: got pending %0d/%0d want 0/0", q0.size(), q1.size());
      end
   endtask

   task automatic test_clear_in_arb();
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 32'h12345678;
      #1;
      checks++;
      if ({gnt0, gnt1, mem_wr, mem_addr, mem_bin} !== {3'b011, 8'h20, 32'h12345678}) begin
         errors++;
         $display("FAIL p1_write: got g0=%b g1=%b wr=%b a=%h d=%h", gnt0, gnt1, mem_wr,
                  mem_addr, mem_bin);
      end
      exp_last = 1'b1;
      @(negedge clk);
      req1 = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h30;
      clear_start = 1'b1;
      #1;
      checks++;
      if ({gnt0, gnt1, mem_wr, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL clear_cycle: got g0=%b g1=%b wr=%b busy=%b want 0000",
                  gnt0, gnt1, mem_wr, busy);
      end
      @(negedge clk);
      clear_start = 1'b0;
      for (int k = 0; k < 256; k++) begin
         #1;
         checks++;
         if ({busy, gnt0, mem_wr, mem_addr} !== {3'b101, 8'(k)}) begin
            errors++;
            $display("FAIL resweep k=%0d: got busy=%b g0=%b wr=%b a=%h", k, busy, gnt0,
                     mem_wr, mem_addr);
         end
         @(negedge clk);
      end
      #1;
      checks++;
      if ({busy, gnt0, mem_addr} !== {2'b01, 8'h30}) begin
         errors++;
         $display("FAIL post_clear_gnt: got busy=%b g0=%b a=%h want 0 1 30", busy, gnt0,
                  mem_addr);
      end
      q0.push_back(32'h30);
      exp_last = 1'b0;
      @(negedge clk);
      addr0 = 8'h20;
      #1;
      q0.push_back(32'h20);
      @(negedge clk);
      req0 = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (q0.size() != 0) begin
         errors++;
         $display("FAIL clear_drain: got pending %0d want 0", q0.size());
      end
   endtask

   task automatic test_reset_mid_sweep();
      @(negedge clk);
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      repeat (100) @(negedge clk);
      #1;
      checks++;
      if ({busy, mem_addr} !== {1'b1, 8'd100}) begin
         errors++;
         $display("FAIL mid_sweep_addr: got busy=%b a=%0d want 1 100", busy, mem_addr);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({busy, mem_wr, rvalid0, rvalid1, rdata0, rdata1} !== {4'b1000, 64'h0}) begin
         errors++;
         $display("FAIL mid_reset: got busy=%b wr=%b rv=%b%b rd=%h %h", busy, mem_wr,
                  rvalid0, rvalid1, rdata0, rdata1);
      end
      @(negedge clk);
      reset = 1'b0;
      exp_last = 1'b1;
      for (int k = 0; k < 256; k++) begin
         #1;
         checks++;
         if ({busy, mem_wr, mem_addr, mem_bin} !== {2'b11, 8'(k), 32'(k)}) begin
            errors++;
            $display("FAIL restart k=%0d: got busy=%b wr=%b a=%h d=%h", k, busy, mem_wr,
                     mem_addr, mem_bin);
         end
         @(negedge clk);
      end
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL restart_end: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_clear_ignored();
      @(negedge clk);
      clear_start = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 256; k++) begin
         clear_start = (k == 50);
         #1;
         checks++;
         if ({busy, mem_wr, mem_addr} !== {2'b11, 8'(k)}) begin
            errors++;
            $display("FAIL ignore k=%0d: got busy=%b wr=%b a=%h", k, busy, mem_wr, mem_addr);
         end
         @(negedge clk);
      end
      clear_start = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore_end: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_back_to_back_after_reset();
      logic eg0;
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
      req1 = 1'b1; we1 = 1'b0; addr1 = 8'h06;
      for (int i = 0; i < 4; i++) begin
         #1;
         eg0 = exp_last;
         checks++;
         if ({gnt0, gnt1} !== {eg0, ~eg0}) begin
            errors++;
            $display("FAIL b2b_grant i=%0d: got g0=%b g1=%b want %b %b", i, gnt0, gnt1,
                     eg0, ~eg0);
         end
         if (eg0) q0.push_back(32'h5);
         else     q1.push_back(32'h6);
         exp_last = ~eg0;
         @(negedge clk);
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL b2b_drain: got pending %0d/%0d want 0/0", q0.size(), q1.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) bmem[i] = 32'h0;
      reset = 1'b1; clear_start = 1'b0;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      exp_last = 1'b1;
      test_reset();
      test_port0_rw();
      test_round_robin();
      test_clear_in_arb();
      test_reset_mid_sweep();
      test_back_to_back_after_reset();
      test_clear_ignored();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
